psum_deskew_collector: RTL and testbench

PSUM_DESKEW_COLLECTOR -- requirements
Module: psum_deskew_collector

---
 rtl/psum_deskew_collector.sv | 122 ++++++++++++
 tb/tb_psum_deskew_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/psum_deskew_collector.sv
// psum_deskew_collector: captures one skewed row of systolic-array column outputs, then drains it in column order.
// Latency: column 0 is sampled LATENCY edges after start, column c SKEW*c edges later; first word is valid the cycle after the last sample.
// Backpressure: out_valid/out_ready handshake; words hold stable for any number of stalled cycles, start is ignored while busy.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start               - one-cycle request to collect a row (only honoured in IDLE)
//   psum_col_out_vec    - array column outputs, column c at [c*DATA_W +: DATA_W]
//   busy                - high whenever the FSM is not in IDLE
//   out_valid/out_ready - output handshake
//   out_data/out_col    - collected word and its column index
//   out_last            - marks the column N_COLS-1 word
module psum_deskew_collector #(
   parameter int N_COLS  = 8,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 17,
   parameter int SKEW    = 1,
   localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [N_COLS*DATA_W-1:0]   psum_col_out_vec,
   output logic                       busy,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [COL_W-1:0]           out_col,
   output logic                       out_last
);

   // Counter sized for the full span from start to the last sample.
   localparam int SPAN  = LATENCY + (N_COLS - 1) * SKEW;
   localparam int CNT_W = $clog2(SPAN + 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      CAPTURE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   // Shared index: column being captured in WAIT/CAPTURE, word being drained in DRAIN.
   logic [COL_W-1:0]   idx;
   logic [DATA_W-1:0]  buffer [N_COLS];
   logic               sample;

   // Next-state logic. The sample for column 0 happens on the edge that leaves WAIT,
   // which keeps LATENCY=1 legal (the counter is loaded with LATENCY-1 at start).
   always_comb begin
      state_nxt = state;
      sample    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == '0) begin
               sample    = 1'b1;
               state_nxt = (N_COLS == 1) ? DRAIN : CAPTURE;
            end
         end
         CAPTURE: begin
            if (cnt == '0) begin
               sample = 1'b1;
               if (idx == LAST_COL) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready && idx == LAST_COL) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Counter, index and capture buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
         for (int i = 0; i < N_COLS; i++) buffer[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt <= CNT_W'(LATENCY - 1);
                  idx <= '0;
               end
            end
            WAIT, CAPTURE: begin
               if (sample) begin
                  buffer[idx] <= psum_col_out_vec[idx*DATA_W +: DATA_W];
                  cnt         <= CNT_W'(SKEW - 1);
                  // Wrap to 0 after the last column so DRAIN starts at word 0.
                  idx         <= (idx == LAST_COL) ? '0 : idx + 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DRAIN: begin
               if (out_ready) idx <= (idx == LAST_COL) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign out_valid = (state == DRAIN);
   assign out_data  = out_valid ? buffer[idx] : '0;
   assign out_col   = out_valid ? idx : '0;
   assign out_last  = out_valid && (idx == LAST_COL);

endmodule

// File: tb/tb_psum_deskew_collector.sv
// Testbench for psum_deskew_collector: two instances (default timing, and LATENCY=3/SKEW=2),
// directed rows with a scoreboard filled as column values are driven and drained as words transfer.
module tb_psum_deskew_collector;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start_a = 0, ready_a = 0;
   logic [255:0] vec_a = '0;
   logic        busy_a, valid_a, last_a;
   logic [31:0] data_a;
   logic [2:0]  col_a;

   logic        start_b = 0, ready_b = 0;
   logic [255:0] vec_b = '0;
   logic        busy_b, valid_b, last_b;
   logic [31:0] data_b;
   logic [2:0]  col_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] d;
      logic [2:0]  c;
      logic        l;
   } exp_t;
   exp_t q[$];

   logic [31:0] col_val [8];

   always #5 clk = ~clk;

   psum_deskew_collector #(.N_COLS(8), .DATA_W(32), .LATENCY(17), .SKEW(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .psum_col_out_vec(vec_a),
      .busy(busy_a), .out_valid(valid_a), .out_ready(ready_a),
      .out_data(data_a), .out_col(col_a), .out_last(last_a));

   psum_deskew_collector #(.N_COLS(8), .DATA_W(32), .LATENCY(3), .SKEW(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .psum_col_out_vec(vec_b),
      .busy(busy_b), .out_valid(valid_b), .out_ready(ready_b),
      .out_data(data_b), .out_col(col_b), .out_last(last_b));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One row on instance sel. Entered at a negedge; edge e (relative to T0) is the next posedge.
   task automatic run_row(input int sel, input int lat, input int skw, input logic [31:0] fill,
                          input bit toggle_rdy, input bit extra_starts, input int exp_first);
      int  first = -1;
      int  got = 0;
      int  done_edge = -1;
      logic [255:0] v;
      logic rdy, st, o_valid, o_busy, o_last;
      logic [31:0] o_data;
      logic [2:0]  o_col;
      exp_t e_item;
      q.delete();
      for (int e = 0; e < 300; e++) begin
         if (sel == 0) begin
            o_valid = valid_a; o_busy = busy_a; o_last = last_a; o_data = data_a; o_col = col_a;
         end else begin
            o_valid = valid_b; o_busy = busy_b; o_last = last_b; o_data = data_b; o_col = col_b;
         end
         rdy = toggle_rdy ? (e % 3 == 0) : 1'b1;
         if (e == 1) chk("busy_in_wait", o_busy, 1);
         if (o_valid) begin
            if (first < 0) first = e;
            if (q.size() == 0) begin
               chk("valid_with_empty_scoreboard", o_valid, 0);
            end else begin
               chk("out_data", o_data, q[0].d);
               chk("out_col", o_col, q[0].c);
               chk("out_last", o_last, q[0].l);
               if (rdy) begin
                  e_item = q.pop_front();
                  got++;
                  if (e_item.l) done_edge = e;
               end
            end
         end else begin
            chk("last_without_valid", o_last, 0);
         end
         st = (e == 0) || (extra_starts && (e == 5 || done_edge == e));
         v = {8{fill}};
         for (int c = 0; c < 8; c++) begin
            if (e == lat + c * skw) begin
               v[c*32 +: 32] = col_val[c];
               e_item.d = col_val[c];
               e_item.c = 3'(c);
               e_item.l = (c == 7);
               q.push_back(e_item);
            end
         end
         if (sel == 0) begin
            start_a = st; vec_a = v; ready_a = rdy;
         end else begin
            start_b = st; vec_b = v; ready_b = rdy;
         end
         @(posedge clk);
         @(negedge clk);
         if (done_edge >= 0) break;
      end
      start_a = 0; vec_a = '0; ready_a = 0;
      start_b = 0; vec_b = '0; ready_b = 0;
      chk("row_completed", (done_edge >= 0), 1);
      chk("first_valid_edge", first, exp_first);
      chk("word_count", got, 8);
      chk("scoreboard_empty", q.size(), 0);
      if (!toggle_rdy) chk("last_transfer_edge", done_edge, exp_first + 7);
      chk("busy_after_last", (sel == 0) ? busy_a : busy_b, 0);
      chk("valid_after_last", (sel == 0) ? valid_a : valid_b, 0);
      @(negedge clk);
      chk("still_idle", (sel == 0) ? busy_a : busy_b, 0);
   endtask

   initial begin
      int seen;
      for (int c = 0; c < 8; c++) col_val[c] = 32'(12 + c);

      // Reset state, with clock running and rst held high
      #23;
      chk("rst_busy", busy_a, 0);
      chk("rst_valid", valid_a, 0);
      chk("rst_last", last_a, 0);
      chk("rst_data", data_a, 0);
      chk("rst_col", col_a, 0);
      chk("rst_b_valid", valid_b, 0);
      @(negedge clk);
      rst = 0;

      // Default row, ready always high
      run_row(0, 17, 1, 32'h0, 1'b0, 1'b0, 25);
      // Ready toggling 1,0,0
      run_row(0, 17, 1, 32'h0, 1'b1, 1'b0, 25);
      // Extra starts at T0+5 and at the final transfer
      run_row(0, 17, 1, 32'h0, 1'b0, 1'b1, 25);

      // Reset mid-CAPTURE at T0+20
      start_a = 1;
      @(posedge clk); @(negedge clk);
      start_a = 0;
      for (int i = 1; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
      end
      chk("busy_before_reset", busy_a, 1);
      rst = 1;
      #1;
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_valid", valid_a, 0);
      chk("mid_rst_last", last_a, 0);
      chk("mid_rst_data", data_a, 0);
      chk("mid_rst_col", col_a, 0);
      @(negedge clk);
      rst = 0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); @(negedge clk);
         if (valid_a || busy_a) seen++;
      end
      chk("no_activity_after_reset", seen, 0);
      run_row(0, 17, 1, 32'h0, 1'b0, 1'b0, 25);

      // LATENCY=3, SKEW=2, filler 0xDEADBEEF outside the sample edges
      for (int c = 0; c < 8; c++) col_val[c] = 32'(100 + c);
      run_row(1, 3, 2, 32'hDEADBEEF, 1'b0, 1'b0, 18);
      run_row(1, 3, 2, 32'hDEADBEEF, 1'b1, 1'b0, 18);

      // Full-width pass-through
      for (int c = 0; c < 8; c++) col_val[c] = 32'(12 + c);
      col_val[3] = 32'hFFFF_FFFF;
      col_val[7] = 32'h8000_0001;
      run_row(0, 17, 1, 32'h0, 1'b0, 1'b0, 25);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
